pipe_stage_skid: RTL and testbench

//  Generic inter-stage pipeline register for the RISC-V core, replacing the per-field dff banks in the IF/ID, ID/EX, EX/MEM and MEM/WB stages.

---
 rtl/pipe_stage_skid.sv | 130 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// stall (hold) and flush (bubble) controls, and an optional 2-entry skid
// buffer that registers in_ready.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic              ready_q;
  logic              in_fire, out_fire;
  logic              load_main_in, load_main_skid, load_skid;

  // Handshake decode; in_ready comes from a flop when the skid buffer is built.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    out_fire  = out_valid & out_ready & ~stall;
    in_ready  = (SKID != 0) ? ready_q : (~out_valid | out_fire);
    in_fire   = in_valid & in_ready;
    out_data  = main_data_q;
    out_ctrl  = out_valid ? main_ctrl_q : '0;
  end

  // Next-state and register-load decode; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d      = ST_FULL;
          load_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          // Only reachable with the skid buffer: without it, in_ready
          // in FULL equals out_fire.
          state_d   = ST_SKID;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_fire) begin
          state_d        = ST_FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Occupancy follows directly from the state.
  always_comb begin
    case (state_q)
      ST_FULL: occupancy = 2'd1;
      ST_SKID: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // State register and registered ready (low only while the skid entry is held).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_SKID);
    end
  end

  // Payload registers; main refills from the skid entry when it drains.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (load_main_in) begin
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
      end else if (load_main_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance share the
// same inputs; each is checked against a queue-based FIFO model, plus a
// table of hand-derived vectors and directed multi-cycle sequences.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst, flush, stall, in_valid, out_ready;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        rdy1, v1, rdy0, v0;
  logic [31:0] d1, d0;
  logic [15:0] c1, c0;
  logic [1:0]  o1, o0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .SKID(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_ctrl(c1),
    .occupancy(o1)
  );

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .SKID(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_ctrl(c0),
    .occupancy(o0)
  );

  // Reference model: each stage is a FIFO of {ctrl,data} with capacity 2 (SKID=1)
  // or 1 (SKID=0).
  logic [47:0] q1[$];
  logic [47:0] q0[$];
  bit          model_on = 0;
  bit          acc0 = 0;

  function automatic bit exp_ready(input int k, input int n);
    if (k == 1) return n < 2;
    return (n == 0) || (out_ready && !stall);
  endfunction

  always @(posedge clk) begin
    bit fo1, fi1, fo0, fi0;
    acc0 = 0;
    if (!rst) begin
      q1.delete();
      q0.delete();
      model_on = 1;
    end else if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      fo1 = (q1.size() > 0) && out_ready && !stall;
      fi1 = in_valid && exp_ready(1, q1.size());
      fo0 = (q0.size() > 0) && out_ready && !stall;
      fi0 = in_valid && exp_ready(0, q0.size());
      if (fo1) void'(q1.pop_front());
      if (fi1) q1.push_back({in_ctrl, in_data});
      if (fo0) void'(q0.pop_front());
      if (fi0) q0.push_back({in_ctrl, in_data});
      acc0 = fi0;
    end
  end

  task automatic cmp(input string nm, input logic [47:0] act, input logic [47:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic check_models();
    logic [47:0] h;
    bit          ev;
    ev = q1.size() > 0;
    h  = ev ? q1[0] : 48'h0;
    cmp("m1_valid", {47'h0, v1}, {47'h0, ev});
    cmp("m1_ready", {47'h0, rdy1}, {47'h0, exp_ready(1, q1.size())});
    cmp("m1_occ", {46'h0, o1}, 48'(q1.size()));
    cmp("m1_ctrl", {32'h0, c1}, {32'h0, h[47:32]});
    if (ev) cmp("m1_data", {16'h0, d1}, {16'h0, h[31:0]});
    ev = q0.size() > 0;
    h  = ev ? q0[0] : 48'h0;
    cmp("m0_valid", {47'h0, v0}, {47'h0, ev});
    cmp("m0_ready", {47'h0, rdy0}, {47'h0, exp_ready(0, q0.size())});
    cmp("m0_occ", {46'h0, o0}, 48'(q0.size()));
    cmp("m0_ctrl", {32'h0, c0}, {32'h0, h[47:32]});
    if (ev) cmp("m0_data", {16'h0, d0}, {16'h0, h[31:0]});
  endtask

  task automatic tick();
    @(negedge clk);
    if (model_on) check_models();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit f, input bit s, input bit iv,
                       input logic [31:0] d, input bit ordy);
    rst = r; flush = f; stall = s; in_valid = iv; out_ready = ordy;
    in_data = d; in_ctrl = ~d[15:0];
  endtask

  // Hand-derived vectors for the SKID=1 instance; expectations are the
  // outputs observed during the row's cycle, before its closing edge.
  typedef struct {
    bit          r, f, s, iv, ordy;
    logic [31:0] d;
    bit          ev, erdy;
    logic [31:0] ed;
    logic [1:0]  eo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit f, bit s, bit iv, logic [31:0] d, bit ordy,
                              bit ev, logic [31:0] ed, bit erdy, logic [1:0] eo);
    vec_t t;
    t.r = r; t.f = f; t.s = s; t.iv = iv; t.d = d; t.ordy = ordy;
    t.ev = ev; t.ed = ed; t.erdy = erdy; t.eo = eo;
    return t;
  endfunction

  initial begin
    int recv, nxt;
    // rst f  s  iv d     or   ev ed    rdy occ
    tbl.push_back(mk(1, 0, 0, 1, 32'hA,  0,   0, 0,     1,  0)); // push A
    tbl.push_back(mk(1, 0, 0, 1, 32'hB,  0,   1, 32'hA, 1,  1)); // push B -> skid
    tbl.push_back(mk(1, 0, 0, 1, 32'hC,  0,   1, 32'hA, 0,  2)); // C refused
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  1,   1, 32'hA, 0,  2)); // A leaves
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  1,   1, 32'hB, 1,  1)); // B leaves
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  0,   0, 0,     1,  0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h11, 0,   0, 0,     1,  0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h22, 0,   1, 32'h11, 1, 1));
    tbl.push_back(mk(1, 1, 1, 1, 32'h33, 1,   1, 32'h11, 0, 2)); // flush from SKID
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  0,   0, 0,     1,  0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 0,   0, 0,     1,  0));
    tbl.push_back(mk(1, 1, 1, 1, 32'h66, 1,   1, 32'h44, 1, 1)); // flush eats in_fire
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  1,   0, 0,     1,  0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h55, 1,   0, 0,     1,  0));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,  1,   1, 32'h55, 1, 1)); // stalled
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,  1,   1, 32'h55, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,  1,   1, 32'h55, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  1,   1, 32'h55, 1, 1)); // consumed once
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  1,   0, 0,     1,  0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h77, 0,   0, 0,     1,  0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h88, 0,   1, 32'h77, 1, 1)); // reset wins
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  0,   0, 0,     1,  0));

    // Reset
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("rst1_valid", {47'h0, v1}, 48'h0);
    cmp("rst1_ctrl", {32'h0, c1}, 48'h0);
    cmp("rst1_data", {16'h0, d1}, 48'h0);
    cmp("rst1_ready", {47'h0, rdy1}, 48'h1);
    cmp("rst1_occ", {46'h0, o1}, 48'h0);
    cmp("rst0_valid", {47'h0, v0}, 48'h0);
    cmp("rst0_ready", {47'h0, rdy0}, 48'h1);
    cmp("rst0_occ", {46'h0, o0}, 48'h0);
    @(posedge clk); #1;

    // Table vectors
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      @(negedge clk);
      cmp($sformatf("tbl%0d_valid", i), {47'h0, v1}, {47'h0, tbl[i].ev});
      cmp($sformatf("tbl%0d_ready", i), {47'h0, rdy1}, {47'h0, tbl[i].erdy});
      cmp($sformatf("tbl%0d_occ", i), {46'h0, o1}, {46'h0, tbl[i].eo});
      cmp($sformatf("tbl%0d_ctrl", i), {32'h0, c1},
          {32'h0, (tbl[i].ev ? ~tbl[i].ed[15:0] : 16'h0)});
      if (tbl[i].ev) cmp($sformatf("tbl%0d_data", i), {16'h0, d1}, {16'h0, tbl[i].ed});
      check_models();
      @(posedge clk); #1;
    end
    @(negedge clk);
    cmp("post_rst_data", {16'h0, d1}, 48'h0);
    @(posedge clk); #1;

    // Streaming 0..7 with 1-cycle latency
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, i < 8, 32'(i), 1);
      @(negedge clk);
      cmp("strm_ready1", {47'h0, rdy1}, 48'h1);
      cmp("strm_ready0", {47'h0, rdy0}, 48'h1);
      cmp("strm_valid1", {47'h0, v1}, {47'h0, i > 0});
      if (i > 0) begin
        cmp("strm_data1", {16'h0, d1}, 48'(i - 1));
        cmp("strm_data0", {16'h0, d0}, 48'(i - 1));
      end
      check_models();
      @(posedge clk); #1;
    end
    drive(1, 0, 0, 0, 0, 1);
    repeat (3) tick();

    // SKID=0: out_ready toggles; in_ready mirrors out_fire, 16 entries in order
    recv = 0;
    nxt = 0;
    for (int cyc = 0; cyc < 200 && recv < 16; cyc++) begin
      drive(1, 0, 0, nxt < 16, 32'(nxt + 16'h100), cyc[0]);
      @(negedge clk);
      if (q0.size() > 0)
        cmp("s0_ready_mirror", {47'h0, rdy0}, {47'h0, out_ready});
      if (v0 && out_ready) begin
        cmp("s0_order", {16'h0, d0}, 48'(recv + 16'h100));
        recv++;
      end
      check_models();
      @(posedge clk); #1;
      if (acc0) nxt++;
    end
    cmp("s0_count", 48'(recv), 48'd16);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom % 300) != 0;
      flush     = ($urandom % 25) == 0;
      stall     = ($urandom % 4) == 0;
      in_valid  = ($urandom % 3) != 0;
      out_ready = ($urandom % 3) != 0;
      in_data   = $urandom;
      in_ctrl   = 16'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
